// File: rtl/md_unit_p.sv
// Multiply/divide unit owning HI/LO: fixed-latency multiply/accumulate and an iterative radix-2 restoring divider.
// Optional feature: define MD_FLUSH_EN to add the Flush input, which abandons an in-flight operation.
module md_unit_p #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MD_FLUSH_EN
  ,
  input  logic             Flush
`endif
);

  localparam int MAXC = (MULT_LAT > WIDTH + 1) ? MULT_LAT : WIDTH + 1;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa, opb, d1raw, rem;
  logic             negQ, negR;

  logic             flushHit;
`ifdef MD_FLUSH_EN
  assign flushHit = Flush;
`else
  assign flushHit = 1'b0;
`endif

  // Sign-extending both operands to 2*WIDTH makes one truncated multiply serve signed and unsigned ops.
  logic [2*WIDTH-1:0] extA, extB, product, base, mulRes;
  assign extA    = {{WIDTH{op[0] & opa[WIDTH-1]}}, opa};
  assign extB    = {{WIDTH{op[0] & opb[WIDTH-1]}}, opb};
  assign product = extA * extB;
  assign base    = {Hi, Lo};
  assign mulRes  = op[2] ? (op[1] ? base - product : base + product) : product;

  logic [WIDTH-1:0] absD1, absD2;
  assign absD1 = (Op[0] && D1[WIDTH-1]) ? -D1 : D1;
  assign absD2 = (Op[0] && D2[WIDTH-1]) ? -D2 : D2;

  // opa doubles as the dividend shift register; quotient bits enter at its bottom.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] sub, quoFinal, remFinal;
  logic             ge;
  assign trial    = {rem, opa[WIDTH-1]};
  assign ge       = trial >= {1'b0, opb};
  assign sub      = trial[WIDTH-1:0] - opb;
  assign quoFinal = negQ ? -opa : opa;
  assign remFinal = negR ? -rem : rem;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
      d1raw <= '0;
      rem   <= '0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op    <= Op;
            cnt   <= CW'(1);
            Busy  <= 1'b1;
            d1raw <= D1;
            rem   <= '0;
            if (Op[2] | ~Op[1]) begin
              state <= MUL;
              opa   <= D1;
              opb   <= D2;
              negQ  <= 1'b0;
              negR  <= 1'b0;
            end else begin
              state <= DIV;
              opa   <= absD1;
              opb   <= absD2;
              negQ  <= Op[0] & (D1[WIDTH-1] ^ D2[WIDTH-1]);
              negR  <= Op[0] & D1[WIDTH-1];
            end
          end else if (We) begin
            if (HiLo) Hi <= D1;
            else      Lo <= D1;
          end
        end
        MUL: begin
          if (flushHit) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(MULT_LAT)) begin
            {Hi, Lo} <= mulRes;
            state    <= IDLE;
            Busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (flushHit) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(WIDTH + 1)) begin
            // A zero divisor runs the full step count too, but its result is forced here.
            if (opb == '0) begin
              Hi <= d1raw;
              Lo <= '1;
            end else begin
              Hi <= remFinal;
              Lo <= quoFinal;
            end
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            rem <= ge ? sub : trial[WIDTH-1:0];
            opa <= {opa[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
